// File: rtl/iccm_arb_pkg.sv
// iccm_arb_pkg: shared types and constants for the ICCM port arbiter
package iccm_arb_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {BOOT_WAIT, PROGRAM, DRAIN, RUN, PREEMPT} iccm_arb_state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ldr_wr_t;
  localparam logic TAG_BUS = 1'b0;
  localparam logic TAG_LDR = 1'b1;
endpackage

// File: rtl/iccm_port_arbiter_if.sv
// iccm_port_arbiter_if: loader, adapter bus, SRAM and status signals of the arbiter; slave = arbiter side, master = environment side
interface iccm_port_arbiter_if import iccm_arb_pkg::*; #(
  parameter int AddrW = ADDR_W,
  parameter int DataW = DATA_W
);
  logic             ldr_we_i;
  logic [AddrW-1:0] ldr_addr_i;
  logic [DataW-1:0] ldr_wdata_i;
  logic             ldr_done_i;
  logic             bus_req_i;
  logic             bus_we_i;
  logic [AddrW-1:0] bus_addr_i;
  logic [DataW-1:0] bus_wdata_i;
  logic [DataW-1:0] bus_wmask_i;
  logic             bus_gnt_o;
  logic [DataW-1:0] bus_rdata_o;
  logic             bus_rvalid_o;
  logic [1:0]       bus_rerror_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [AddrW-1:0] mem_addr_o;
  logic [DataW-1:0] mem_wdata_o;
  logic [DataW-1:0] mem_wmask_o;
  logic [DataW-1:0] mem_rdata_i;
  logic             mem_rvalid_i;
  logic             core_hold_o;
  logic             ldr_ovf_o;
  modport slave (
    input  ldr_we_i, ldr_addr_i, ldr_wdata_i, ldr_done_i,
    input  bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i, bus_wmask_i,
    output bus_gnt_o, bus_rdata_o, bus_rvalid_o, bus_rerror_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_rdata_i, mem_rvalid_i,
    output core_hold_o, ldr_ovf_o
  );
  modport master (
    output ldr_we_i, ldr_addr_i, ldr_wdata_i, ldr_done_i,
    output bus_req_i, bus_we_i, bus_addr_i, bus_wdata_i, bus_wmask_i,
    input  bus_gnt_o, bus_rdata_o, bus_rvalid_o, bus_rerror_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_rdata_i, mem_rvalid_i,
    input  core_hold_o, ldr_ovf_o
  );
endinterface

// File: rtl/iccm_ldr_fifo.sv
// iccm_ldr_fifo: sync FIFO of any payload type (push/pop/din -> dout/full/empty/count); push accepted when full if popped the same cycle
module iccm_ldr_fifo #(
  parameter type T = logic,
  parameter int Depth = 4,
  localparam int CntW = $clog2(Depth + 1),
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  T                din,
  output T                dout,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);
  T mem [Depth];
  logic [PtrW-1:0] wp, rp;
  logic acc, do_pop;
  assign full = count == CntW'(Depth);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign acc = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (acc) wp <= (wp == PtrW'(Depth - 1)) ? '0 : wp + 1'b1;
      if (do_pop) rp <= (rp == PtrW'(Depth - 1)) ? '0 : rp + 1'b1;
      count <= count + CntW'(acc) - CntW'(do_pop);
    end
  end
  always_ff @(posedge clock) begin
    if (acc) mem[wp] <= din;
  end
endmodule

// File: rtl/iccm_port_arbiter.sv
// iccm_port_arbiter: owns the ICCM SRAM port, arbitrating loader writes (priority) against core bus fetches and holding the core during programming (clock, reset, arb slave interface)
module iccm_port_arbiter import iccm_arb_pkg::*; #(
  parameter int AddrW = ADDR_W,
  parameter int DataW = DATA_W,
  parameter int Outstanding = 2,
  parameter int LdrFifoDepth = 4,
  parameter int BootTimeout = 0
) (
  input logic                clock,
  input logic                reset,
  iccm_port_arbiter_if.slave arb
);
  localparam int OW = $clog2(Outstanding + 1);
  iccm_arb_state_e state, nxt;
  logic [15:0] timer;
  logic [OW-1:0] outst;
  logic hold_q, ovf_q;
  ldr_wr_t ldr_in, ldr_head;
  logic ldr_full, ldr_empty, ldr_push, ldr_pop;
  logic [$clog2(LdrFifoDepth + 1)-1:0] ldr_cnt;
  logic tag_head, tag_full, tag_empty, tag_pop;
  logic [$clog2(Outstanding + 2)-1:0] tag_cnt;
  logic tmo, bus_gnt, bus_rv;
  assign ldr_in = '{addr: arb.ldr_addr_i, wdata: arb.ldr_wdata_i};
  assign tmo = (BootTimeout != 0) && (timer == 16'(BootTimeout - 1));
  assign ldr_push = arb.ldr_we_i && !(state == BOOT_WAIT && tmo);
  assign ldr_pop = (state == PROGRAM || state == DRAIN) && !ldr_empty && (!tag_full || arb.mem_rvalid_i);
  assign bus_gnt = arb.bus_req_i && state == RUN && ldr_cnt == '0 && outst < OW'(Outstanding);
  // Responses arriving with an empty tag queue predate a reset and are dropped.
  assign tag_pop = arb.mem_rvalid_i && !tag_empty;
  assign bus_rv = tag_pop && tag_head == TAG_BUS;
  iccm_ldr_fifo #(.T(ldr_wr_t), .Depth(LdrFifoDepth)) u_ldr_fifo (
    .clock(clock), .reset(reset), .push(ldr_push), .pop(ldr_pop), .din(ldr_in),
    .dout(ldr_head), .full(ldr_full), .empty(ldr_empty), .count(ldr_cnt)
  );
  iccm_ldr_fifo #(.T(logic), .Depth(Outstanding + 1)) u_tag_fifo (
    .clock(clock), .reset(reset), .push(arb.mem_req_o), .pop(tag_pop),
    .din(ldr_pop ? TAG_LDR : TAG_BUS),
    .dout(tag_head), .full(tag_full), .empty(tag_empty), .count(tag_cnt)
  );
  always_comb begin
    nxt = state;
    case (state)
      BOOT_WAIT: nxt = tmo ? RUN : arb.ldr_we_i ? PROGRAM : BOOT_WAIT;
      PROGRAM:   nxt = arb.ldr_done_i ? DRAIN : PROGRAM;
      DRAIN:     nxt = arb.ldr_we_i ? PROGRAM : (ldr_empty && tag_cnt == '0) ? RUN : DRAIN;
      RUN:       nxt = arb.ldr_we_i ? PREEMPT : RUN;
      PREEMPT:   nxt = (outst == '0) ? PROGRAM : PREEMPT;
      default:   nxt = BOOT_WAIT;
    endcase
  end
  // Hold stays low while preempted reads are still in flight so the core can retire them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= BOOT_WAIT;
      timer <= '0;
      outst <= '0;
      hold_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      state <= nxt;
      timer <= (state == BOOT_WAIT && nxt == BOOT_WAIT) ? timer + 16'(timer != '1) : '0;
      outst <= outst + OW'(bus_gnt) - OW'(bus_rv);
      hold_q <= !(state == RUN || (state == PREEMPT && outst != '0));
      ovf_q <= ovf_q || (ldr_push && ldr_full && !ldr_pop);
    end
  end
  assign arb.bus_gnt_o = bus_gnt;
  assign arb.bus_rvalid_o = bus_rv;
  assign arb.bus_rdata_o = bus_rv ? arb.mem_rdata_i : '0;
  assign arb.bus_rerror_o = 2'b00;
  assign arb.mem_req_o = ldr_pop || bus_gnt;
  assign arb.mem_we_o = ldr_pop || (bus_gnt && arb.bus_we_i);
  assign arb.mem_addr_o = ldr_pop ? ldr_head.addr : bus_gnt ? arb.bus_addr_i : {AddrW{1'b0}};
  assign arb.mem_wdata_o = ldr_pop ? ldr_head.wdata : bus_gnt ? arb.bus_wdata_i : '0;
  assign arb.mem_wmask_o = ldr_pop ? {DataW{1'b1}} : bus_gnt ? arb.bus_wmask_i : '0;
  assign arb.core_hold_o = hold_q;
  assign arb.ldr_ovf_o = ovf_q;
endmodule

// File: tb/tb_iccm_port_arbiter.sv
// tb_iccm_port_arbiter: directed self-checking bench with a small SRAM model (optional response stall)
module tb_iccm_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit stall = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  iccm_port_arbiter_if #(.AddrW(12), .DataW(32)) ifc ();
  iccm_port_arbiter #(
    .AddrW(12), .DataW(32), .Outstanding(2), .LdrFifoDepth(4), .BootTimeout(8)
  ) dut (
    .clock(clk),
    .reset(rst),
    .arb(ifc.slave)
  );
  bit [31:0] mem [4096];
  bit wr_v [4096];
  bit [31:0] rq [16];
  bit [3:0] wp, rp;
  function automatic logic [31:0] rd(input logic [11:0] a);
    return wr_v[a] ? mem[a] : (32'hA000_0000 | 32'(a));
  endfunction
  assign ifc.mem_rvalid_i = (wp != rp) && !stall;
  assign ifc.mem_rdata_i = rq[rp];
  always @(posedge clk) begin
    if (ifc.mem_rvalid_i) rp <= rp + 1'b1;
    if (ifc.mem_req_o) begin
      rq[wp] <= rd(ifc.mem_addr_o);
      wp <= wp + 1'b1;
      if (ifc.mem_we_o) begin
        mem[ifc.mem_addr_o] <= (rd(ifc.mem_addr_o) & ~ifc.mem_wmask_o) | (ifc.mem_wdata_o & ifc.mem_wmask_o);
        wr_v[ifc.mem_addr_o] <= 1'b1;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_hold(input logic v, input string tag);
    int k = 0;
    while (ifc.core_hold_o !== v && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, ifc.core_hold_o, v);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    ifc.ldr_we_i = 0; ifc.ldr_addr_i = 0; ifc.ldr_wdata_i = 0; ifc.ldr_done_i = 0;
    ifc.bus_req_i = 0; ifc.bus_we_i = 0; ifc.bus_addr_i = 0; ifc.bus_wdata_i = 0; ifc.bus_wmask_i = 0;
    // reset state, with a pending bus request that must not be granted
    repeat (2) @(negedge clk);
    ifc.bus_req_i = 1; ifc.bus_addr_i = 12'h004;
    #1;
    chk("rst_hold", ifc.core_hold_o, 1);
    chk("rst_gnt", ifc.bus_gnt_o, 0);
    chk("rst_mem_req", ifc.mem_req_o, 0);
    chk("rst_ovf", ifc.ldr_ovf_o, 0);
    chk("rst_rerror", ifc.bus_rerror_o, 0);
    // T1: boot timeout of 8 cycles
    @(negedge clk); rst = 0;
    repeat (7) @(negedge clk);
    #1;
    chk("t1_no_gnt_before_timeout", ifc.bus_gnt_o, 0);
    @(negedge clk); #1;
    chk("t1_gnt_in_run", ifc.bus_gnt_o, 1);
    chk("t1_hold_still_high", ifc.core_hold_o, 1);
    @(negedge clk); ifc.bus_req_i = 0; #1;
    chk("t1_hold_low", ifc.core_hold_o, 0);
    chk("t1_rvalid", ifc.bus_rvalid_o, 1);
    chk("t1_rdata", ifc.bus_rdata_o, 32'hA000_0004);
    // T2: program three words then done
    @(negedge clk); rst = 1; #1;
    chk("t2_rst_hold", ifc.core_hold_o, 1);
    @(negedge clk); rst = 0;
    ifc.ldr_we_i = 1; ifc.ldr_addr_i = 12'h000; ifc.ldr_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk); ifc.ldr_addr_i = 12'h001; ifc.ldr_wdata_i = 32'h1111_1111; #1;
    chk("t2_w0_req", ifc.mem_req_o, 1);
    chk("t2_w0_we", ifc.mem_we_o, 1);
    chk("t2_w0_addr", ifc.mem_addr_o, 12'h000);
    chk("t2_w0_data", ifc.mem_wdata_o, 32'hDEAD_BEEF);
    chk("t2_w0_mask", ifc.mem_wmask_o, 32'hFFFF_FFFF);
    @(negedge clk); ifc.ldr_addr_i = 12'h002; ifc.ldr_wdata_i = 32'h2222_2222; ifc.ldr_done_i = 1; #1;
    chk("t2_w1_addr", ifc.mem_addr_o, 12'h001);
    chk("t2_w1_data", ifc.mem_wdata_o, 32'h1111_1111);
    chk("t2_ldr_resp_absorbed", ifc.bus_rvalid_o, 0);
    @(negedge clk); ifc.ldr_we_i = 0; ifc.ldr_done_i = 0; #1;
    chk("t2_w2_addr", ifc.mem_addr_o, 12'h002);
    chk("t2_w2_data", ifc.mem_wdata_o, 32'h2222_2222);
    chk("t2_ldr_resp_absorbed2", ifc.bus_rvalid_o, 0);
    @(negedge clk); #1;
    chk("t2_no_more_writes", ifc.mem_req_o, 0);
    chk("t2_hold_in_drain", ifc.core_hold_o, 1);
    wait_hold(0, "t2_run");
    ifc.bus_req_i = 1; ifc.bus_addr_i = 12'h000; #1;
    chk("t2_gnt", ifc.bus_gnt_o, 1);
    @(negedge clk); ifc.bus_req_i = 0; #1;
    chk("t2_rvalid", ifc.bus_rvalid_o, 1);
    chk("t2_rdata", ifc.bus_rdata_o, 32'hDEAD_BEEF);
    // T3: outstanding limit with stalled responses
    @(negedge clk); stall = 1; ifc.bus_req_i = 1; ifc.bus_addr_i = 12'h005; #1;
    chk("t3_gnt1", ifc.bus_gnt_o, 1);
    @(negedge clk); ifc.bus_addr_i = 12'h006; #1;
    chk("t3_gnt2", ifc.bus_gnt_o, 1);
    @(negedge clk); ifc.bus_addr_i = 12'h007; #1;
    chk("t3_gnt3_blocked", ifc.bus_gnt_o, 0);
    @(negedge clk); #1;
    chk("t3_gnt3_still_blocked", ifc.bus_gnt_o, 0);
    @(negedge clk); stall = 0; #1;
    chk("t3_gnt3_blocked_on_resp", ifc.bus_gnt_o, 0);
    chk("t3_rvalid5", ifc.bus_rvalid_o, 1);
    chk("t3_rdata5", ifc.bus_rdata_o, 32'hA000_0005);
    @(negedge clk); #1;
    chk("t3_gnt3_after_resp", ifc.bus_gnt_o, 1);
    chk("t3_rdata6", ifc.bus_rdata_o, 32'hA000_0006);
    @(negedge clk); ifc.bus_req_i = 0; #1;
    chk("t3_rdata7", ifc.bus_rdata_o, 32'hA000_0007);
    @(negedge clk); #1;
    chk("t3_idle_rvalid", ifc.bus_rvalid_o, 0);
    // T4: preempt with two reads in flight
    @(negedge clk); stall = 1; ifc.bus_req_i = 1; ifc.bus_addr_i = 12'h008; #1;
    chk("t4_gnt1", ifc.bus_gnt_o, 1);
    @(negedge clk); ifc.bus_addr_i = 12'h009; #1;
    chk("t4_gnt2", ifc.bus_gnt_o, 1);
    @(negedge clk); ifc.bus_req_i = 0;
    ifc.ldr_we_i = 1; ifc.ldr_addr_i = 12'h010; ifc.ldr_wdata_i = 32'hCAFE_F00D; #1;
    chk("t4_hold_run", ifc.core_hold_o, 0);
    @(negedge clk); ifc.ldr_we_i = 0; ifc.bus_req_i = 1; ifc.bus_addr_i = 12'h00A; #1;
    chk("t4_no_gnt", ifc.bus_gnt_o, 0);
    chk("t4_no_mem_req", ifc.mem_req_o, 0);
    @(negedge clk); #1;
    chk("t4_hold_while_pending", ifc.core_hold_o, 0);
    @(negedge clk); stall = 0; #1;
    chk("t4_rdata8", ifc.bus_rdata_o, 32'hA000_0008);
    chk("t4_no_gnt_resp", ifc.bus_gnt_o, 0);
    @(negedge clk); #1;
    chk("t4_rdata9", ifc.bus_rdata_o, 32'hA000_0009);
    chk("t4_hold_last_resp", ifc.core_hold_o, 0);
    @(negedge clk); #1;
    chk("t4_no_issue_preempt", ifc.mem_req_o, 0);
    @(negedge clk); #1;
    chk("t4_hold_program", ifc.core_hold_o, 1);
    chk("t4_wr_req", ifc.mem_req_o, 1);
    chk("t4_wr_we", ifc.mem_we_o, 1);
    chk("t4_wr_addr", ifc.mem_addr_o, 12'h010);
    chk("t4_wr_data", ifc.mem_wdata_o, 32'hCAFE_F00D);
    chk("t4_no_gnt_program", ifc.bus_gnt_o, 0);
    @(negedge clk); ifc.bus_req_i = 0; ifc.ldr_done_i = 1;
    @(negedge clk); ifc.ldr_done_i = 0; #1;
    wait_hold(0, "t4_run");
    ifc.bus_req_i = 1; ifc.bus_addr_i = 12'h010; #1;
    chk("t4_gnt_readback", ifc.bus_gnt_o, 1);
    @(negedge clk); ifc.bus_req_i = 0; #1;
    chk("t4_readback", ifc.bus_rdata_o, 32'hCAFE_F00D);
    // T5: loader FIFO overflow during preempt
    @(negedge clk); stall = 1; ifc.bus_req_i = 1; ifc.bus_addr_i = 12'h001; #1;
    chk("t5_gnt1", ifc.bus_gnt_o, 1);
    @(negedge clk); ifc.bus_addr_i = 12'h002; #1;
    chk("t5_gnt2", ifc.bus_gnt_o, 1);
    @(negedge clk); ifc.bus_req_i = 0;
    for (int i = 0; i < 6; i++) begin
      ifc.ldr_we_i = 1; ifc.ldr_addr_i = 12'(12'h020 + i); ifc.ldr_wdata_i = 32'(32'h100 + i);
      #1;
      chk("t5_ovf_progress", ifc.ldr_ovf_o, (i == 5) ? 1 : 0);
      @(negedge clk);
    end
    ifc.ldr_we_i = 0; #1;
    chk("t5_ovf_set", ifc.ldr_ovf_o, 1);
    @(negedge clk); stall = 0; #1;
    chk("t5_rdata1", ifc.bus_rdata_o, 32'h1111_1111);
    @(negedge clk); #1;
    chk("t5_rdata2", ifc.bus_rdata_o, 32'h2222_2222);
    for (int k = 0; k < 20 && ifc.mem_req_o !== 1'b1; k++) begin
      @(negedge clk); #1;
    end
    chk("t5_program_start", ifc.mem_req_o, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t5_wr_addr", ifc.mem_addr_o, 12'(12'h020 + i));
      chk("t5_wr_data", ifc.mem_wdata_o, 32'(32'h100 + i));
      @(negedge clk); #1;
    end
    chk("t5_dropped_not_issued", ifc.mem_req_o, 0);
    ifc.ldr_done_i = 1;
    @(negedge clk); ifc.ldr_done_i = 0; #1;
    wait_hold(0, "t5_run");
    chk("t5_ovf_sticky_run", ifc.ldr_ovf_o, 1);
    // T6: reset in PROGRAM with two FIFO entries
    @(negedge clk); ifc.ldr_we_i = 1; ifc.ldr_addr_i = 12'h030; ifc.ldr_wdata_i = 32'h300;
    @(negedge clk); ifc.ldr_addr_i = 12'h031; ifc.ldr_wdata_i = 32'h301;
    @(negedge clk); ifc.ldr_addr_i = 12'h032; ifc.ldr_wdata_i = 32'h302; #1;
    chk("t6_w0_addr", ifc.mem_addr_o, 12'h030);
    @(negedge clk); ifc.ldr_we_i = 0; #1;
    chk("t6_w1_addr", ifc.mem_addr_o, 12'h031);
    rst = 1; #1;
    chk("t6_rst_no_req", ifc.mem_req_o, 0);
    chk("t6_rst_hold", ifc.core_hold_o, 1);
    chk("t6_rst_resp_ignored", ifc.bus_rvalid_o, 0);
    chk("t6_rst_ovf_clear", ifc.ldr_ovf_o, 0);
    @(negedge clk); #1;
    chk("t6_rst_no_req2", ifc.mem_req_o, 0);
    @(negedge clk); rst = 0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("t6_after_rst_no_req", ifc.mem_req_o, 0);
      chk("t6_after_rst_hold", ifc.core_hold_o, 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
